mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-port arbiter that shares the single memory bus (bootloader RAM / SDRAM memory subsystem) between the CPU instruction-fetch port (port 0) and the load/store port (port 1). It accepts level-held requests from both masters, grants one at a time round-robin, issues a one-cycle transaction strobe to the memory subsystem, waits for its one-cycle completion strobe, and returns read data plus a one-cycle done pulse to the granted master. It also rejects illegal size codes and guards against a hung memory with a timeout.

## Interface
Parameters:
- TIMEOUT_CYCLES, 4095: max cycles in WAIT before error completion; counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- i_clk  in  1  single clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_mN_req  in  1  request, N=0,1; held high with stable fields until o_mN_done
- i_mN_addr  in  32  byte address
- i_mN_wdata  in  32  write data
- i_mN_bhw  in  3  size: 3'b001 byte, 3'b010 half, 3'b100 word
- i_mN_write  in  1  1=write, 0=read
- o_mN_done  out  1  one-cycle completion pulse
- o_mN_rdata  out  32  read data, valid with o_mN_done
- o_mN_err  out  1  error flag, valid with o_mN_done
- o_mem_data  out  32  to memory bus data
- o_mem_addr  out  32  to memory bus address
- o_mem_bhw  out  3  to memory size
- o_mem_write  out  1  to memory write/not-read
- o_mem_dv  out  1  one-cycle transaction strobe
- i_mem_data  in  32  memory read data
- i_mem_dv  in  1  memory one-cycle completion strobe

## Operation
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE: if any req, pick winner; latch its addr/wdata/bhw/write into o_mem_* registers, record grant index. Legal bhw -> ISSUE; illegal bhw (anything but 001/010/100) -> DONE with err=1, no memory strobe.
- Arbitration: one requester -> it wins. Both -> port not equal to last_grant wins. last_grant updates on every grant (including illegal-bhw grants). Reset value last_grant=1, so port 0 wins first tie.
- ISSUE: o_mem_dv=1 for exactly this cycle; clear timeout counter; -> WAIT.
- WAIT: on i_mem_dv: capture i_mem_data (reads); for writes capture 0. -> DONE, err=0. Else increment counter; when counter reaches TIMEOUT_CYCLES -> DONE with err=1, rdata=0, set drain flag.
- DONE: assert o_mN_done for granted port only, rdata/err valid, other port outputs 0. Req inputs ignored this cycle. -> DRAIN if drain flag, else IDLE.
- DRAIN: wait for the late i_mem_dv, discard it, clear drain flag -> IDLE. No new issue while draining.
- i_mem_dv in IDLE, ISSUE or DONE is ignored (stray).
- o_mem_* fields hold their latched value until the next grant.

## Timing
- Reset (i_rst_n low at posedge): state=IDLE, last_grant=1, counter=0, drain flag=0; all outputs 0 (o_mem_dv, o_mN_done, o_mN_err, o_mN_rdata, o_mem_data/addr/bhw/write).
- Reset mid-transaction aborts without done; memory is not reset by this block, and its late i_mem_dv arrives in IDLE and is ignored.
- Latency: req seen in IDLE cycle 0 -> o_mem_dv in cycle 1 -> i_mem_dv in cycle k (k>=2) -> o_mN_done in cycle k+1 -> IDLE in cycle k+2. Minimum req-to-done 3 cycles.
- Illegal bhw: req cycle 0 -> done+err in cycle 1.
- Back-to-back: next grant earliest in IDLE one cycle after DONE; o_mem_dv never asserted in consecutive cycles.
- Masters must drop req in the cycle after done; req still high in IDLE then is a new request.
- Timeout fires on the TIMEOUT_CYCLES-th WAIT cycle without i_mem_dv; i_mem_dv in that same cycle takes priority (normal completion, no drain).

## Test plan
- Port 0 read word addr 0x0000_0010, memory returns 0xDEADBEEF 5 cycles after strobe -> o_mem_dv one cycle with addr 0x10, bhw 100, write 0; o_m0_done next cycle after i_mem_dv, o_m0_rdata=0xDEADBEEF, err=0.
- Both ports req same cycle after reset -> port 0 granted first, port 1 granted in IDLE after port 0 done; both held req again -> port 0 next (alternation).
- Port 1 write byte 0xAB to 0x0000_0100 -> o_mem_data=0x0000_00AB, bhw 001, write 1; o_m1_done with rdata=0, err=0.
- Port 1 req with bhw=3'b000 -> no o_mem_dv; o_m1_done+o_m1_err one cycle later.
- TIMEOUT_CYCLES=8, memory silent -> done+err after 8 WAIT cycles; pending port 0 req not issued until injected i_mem_dv in DRAIN, then issued normally.
- Reset asserted in WAIT, stray i_mem_dv 2 cycles after release -> no done on either port, all outputs 0, next request completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between the instruction-fetch port (0)
// and the load/store port (1), with illegal-size rejection and hung-memory timeout.
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_m0_req,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic [2:0]  i_m0_bhw,
  input  logic        i_m0_write,
  output logic        o_m0_done,
  output logic [31:0] o_m0_rdata,
  output logic        o_m0_err,
  input  logic        i_m1_req,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic [2:0]  i_m1_bhw,
  input  logic        i_m1_write,
  output logic        o_m1_done,
  output logic [31:0] o_m1_rdata,
  output logic        o_m1_err,
  output logic [31:0] o_mem_data,
  output logic [31:0] o_mem_addr,
  output logic [2:0]  o_mem_bhw,
  output logic        o_mem_write,
  output logic        o_mem_dv,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_dv
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;

  state_t           state;
  logic             last_grant;
  logic             grant;
  logic             drain;
  logic [CNT_W-1:0] cnt;

  logic             win;
  logic [31:0]      win_addr;
  logic [31:0]      win_wdata;
  logic [2:0]       win_bhw;
  logic             win_write;
  logic [31:0]      cap_data;

  function automatic logic bhw_legal(input logic [2:0] bhw);
    return (bhw == 3'b001) || (bhw == 3'b010) || (bhw == 3'b100);
  endfunction

  // On a tie the port that did not win last time takes the bus.
  always_comb begin
    win       = (i_m0_req && i_m1_req) ? ~last_grant : i_m1_req;
    win_addr  = win ? i_m1_addr  : i_m0_addr;
    win_wdata = win ? i_m1_wdata : i_m0_wdata;
    win_bhw   = win ? i_m1_bhw   : i_m0_bhw;
    win_write = win ? i_m1_write : i_m0_write;
  end

  assign cap_data = o_mem_write ? 32'h0 : i_mem_data;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant       <= 1'b0;
      drain       <= 1'b0;
      cnt         <= '0;
      o_mem_dv    <= 1'b0;
      o_mem_data  <= 32'h0;
      o_mem_addr  <= 32'h0;
      o_mem_bhw   <= 3'b000;
      o_mem_write <= 1'b0;
      o_m0_done   <= 1'b0;
      o_m1_done   <= 1'b0;
      o_m0_err    <= 1'b0;
      o_m1_err    <= 1'b0;
      o_m0_rdata  <= 32'h0;
      o_m1_rdata  <= 32'h0;
    end else begin
      o_mem_dv   <= 1'b0;
      o_m0_done  <= 1'b0;
      o_m1_done  <= 1'b0;
      o_m0_err   <= 1'b0;
      o_m1_err   <= 1'b0;
      o_m0_rdata <= 32'h0;
      o_m1_rdata <= 32'h0;
      case (state)
        IDLE: begin
          if (i_m0_req || i_m1_req) begin
            o_mem_addr  <= win_addr;
            o_mem_data  <= win_wdata;
            o_mem_bhw   <= win_bhw;
            o_mem_write <= win_write;
            grant       <= win;
            last_grant  <= win;
            if (bhw_legal(win_bhw)) begin
              o_mem_dv <= 1'b1;
              state    <= ISSUE;
            end else begin
              // Rejected without ever touching the memory.
              o_m0_done <= ~win;
              o_m1_done <= win;
              o_m0_err  <= ~win;
              o_m1_err  <= win;
              state     <= DONE;
            end
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (i_mem_dv) begin
            o_m0_done  <= ~grant;
            o_m1_done  <= grant;
            o_m0_rdata <= grant ? 32'h0 : cap_data;
            o_m1_rdata <= grant ? cap_data : 32'h0;
            state      <= DONE;
          end else if (cnt == CNT_LAST) begin
            // Memory still owes a strobe; swallow it in DRAIN before reissuing.
            o_m0_done <= ~grant;
            o_m1_done <= grant;
            o_m0_err  <= ~grant;
            o_m1_err  <= grant;
            drain     <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= drain ? DRAIN : IDLE;
        end
        DRAIN: begin
          if (i_mem_dv) begin
            drain <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle vector table plus hand sequences
// for timeout/drain, completion-at-timeout priority and reset mid-transaction.
module tb_mem_bus_arbiter;

  localparam int TO = 8;
  localparam logic [31:0] A0 = 32'h0000_0010;
  localparam logic [31:0] D0 = 32'h1234_5678;
  localparam logic [31:0] A1 = 32'h0000_0100;
  localparam logic [31:0] D1 = 32'h0000_00AB;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_m0_req = 1'b0, i_m1_req = 1'b0;
  logic [31:0] i_m0_addr = A0, i_m1_addr = A1;
  logic [31:0] i_m0_wdata = D0, i_m1_wdata = D1;
  logic [2:0]  i_m0_bhw = 3'b000, i_m1_bhw = 3'b000;
  logic        i_m0_write = 1'b0, i_m1_write = 1'b0;
  logic        o_m0_done, o_m1_done, o_m0_err, o_m1_err;
  logic [31:0] o_m0_rdata, o_m1_rdata;
  logic [31:0] o_mem_data, o_mem_addr;
  logic [2:0]  o_mem_bhw;
  logic        o_mem_write, o_mem_dv;
  logic [31:0] i_mem_data = 32'h0;
  logic        i_mem_dv = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_m0_req(i_m0_req), .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata),
    .i_m0_bhw(i_m0_bhw), .i_m0_write(i_m0_write),
    .o_m0_done(o_m0_done), .o_m0_rdata(o_m0_rdata), .o_m0_err(o_m0_err),
    .i_m1_req(i_m1_req), .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata),
    .i_m1_bhw(i_m1_bhw), .i_m1_write(i_m1_write),
    .o_m1_done(o_m1_done), .o_m1_rdata(o_m1_rdata), .o_m1_err(o_m1_err),
    .o_mem_data(o_mem_data), .o_mem_addr(o_mem_addr), .o_mem_bhw(o_mem_bhw),
    .o_mem_write(o_mem_write), .o_mem_dv(o_mem_dv),
    .i_mem_data(i_mem_data), .i_mem_dv(i_mem_dv)
  );

  typedef struct {
    logic        rst_n;
    logic [1:0]  req;
    logic [2:0]  b0, b1;
    logic [1:0]  wr;
    logic        mdv;
    logic [31:0] mdata;
    logic        e_dv;
    logic [1:0]  e_sel;
    logic [2:0]  e_bhw;
    logic        e_wr;
    logic [1:0]  e_dn, e_er;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mkv(input logic rst_n, input logic [1:0] req, input logic [2:0] b0,
                               input logic [2:0] b1, input logic [1:0] wr, input logic mdv,
                               input logic [31:0] mdata, input logic e_dv, input logic [1:0] e_sel,
                               input logic [2:0] e_bhw, input logic e_wr, input logic [1:0] e_dn,
                               input logic [1:0] e_er, input logic [31:0] e_rd);
    vec_t v;
    v.rst_n = rst_n; v.req = req; v.b0 = b0; v.b1 = b1; v.wr = wr; v.mdv = mdv; v.mdata = mdata;
    v.e_dv = e_dv; v.e_sel = e_sel; v.e_bhw = e_bhw; v.e_wr = e_wr;
    v.e_dn = e_dn; v.e_er = e_er; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic drive(input logic rst_n, input logic [1:0] req, input logic [2:0] b0,
                       input logic [2:0] b1, input logic [1:0] wr, input logic mdv,
                       input logic [31:0] mdata);
    i_rst_n    = rst_n;
    i_m0_req   = req[0];
    i_m1_req   = req[1];
    i_m0_bhw   = b0;
    i_m1_bhw   = b1;
    i_m0_write = wr[0];
    i_m1_write = wr[1];
    i_mem_dv   = mdv;
    i_mem_data = mdata;
    @(posedge i_clk);
    #1;
  endtask

  // e_sel: 0 = bus fields zero, 1 = port 0 fields latched, 2 = port 1 fields latched.
  task automatic cmp(input string tag, input logic e_dv, input logic [1:0] e_sel,
                     input logic [2:0] e_bhw, input logic e_wr, input logic [1:0] e_dn,
                     input logic [1:0] e_er, input logic [31:0] e_rd);
    logic [31:0]  ea, ed, er0, er1, ar0, ar1;
    logic [1:0]   aer;
    logic [136:0] expv, actv;
    ea  = (e_sel == 2'd1) ? A0 : (e_sel == 2'd2) ? A1 : 32'h0;
    ed  = (e_sel == 2'd1) ? D0 : (e_sel == 2'd2) ? D1 : 32'h0;
    er0 = e_dn[0] ? e_rd : 32'h0;
    er1 = e_dn[1] ? e_rd : 32'h0;
    ar0 = o_m0_done ? o_m0_rdata : 32'h0;
    ar1 = o_m1_done ? o_m1_rdata : 32'h0;
    aer = {o_m1_done & o_m1_err, o_m0_done & o_m0_err};
    expv = {e_dv, e_wr, e_bhw, ea, ed, e_dn, e_er & e_dn, er0, er1};
    actv = {o_mem_dv, o_mem_write, o_mem_bhw, o_mem_addr, o_mem_data,
            o_m1_done, o_m0_done, aer, ar0, ar1};
    n_vec++;
    if (actv !== expv) begin
      n_err++;
      $display("FAIL %s: got dv=%b wr=%b bhw=%b addr=%h data=%h done=%b err=%b rd0=%h rd1=%h; want dv=%b wr=%b bhw=%b addr=%h data=%h done=%b err=%b rd0=%h rd1=%h",
               tag, o_mem_dv, o_mem_write, o_mem_bhw, o_mem_addr, o_mem_data,
               {o_m1_done, o_m0_done}, aer, ar0, ar1,
               e_dv, e_wr, e_bhw, ea, ed, e_dn, e_er & e_dn, er0, er1);
    end
  endtask

  task automatic step(input string tag, input logic rst_n, input logic [1:0] req,
                      input logic [2:0] b0, input logic [2:0] b1, input logic [1:0] wr,
                      input logic mdv, input logic [31:0] mdata, input logic e_dv,
                      input logic [1:0] e_sel, input logic [2:0] e_bhw, input logic e_wr,
                      input logic [1:0] e_dn, input logic [1:0] e_er, input logic [31:0] e_rd);
    drive(rst_n, req, b0, b1, wr, mdv, mdata);
    cmp(tag, e_dv, e_sel, e_bhw, e_wr, e_dn, e_er, e_rd);
  endtask

  task automatic chk_reset(input string tag);
    logic [138:0] all;
    all = {o_mem_dv, o_mem_write, o_mem_bhw, o_mem_addr, o_mem_data,
           o_m0_done, o_m1_done, o_m0_err, o_m1_err, o_m0_rdata, o_m1_rdata};
    n_vec++;
    if (all !== '0) begin
      n_err++;
      $display("FAIL %s: outputs after reset %h, want all zero", tag, all);
    end
  endtask

  initial begin
    // Port 0 read word, memory answers in the 5th cycle after the strobe.
    vq.push_back(mkv(1, 2'b01, 3'b100, 3'b000, 2'b00, 0, 32'h0, 1, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0));
    for (int i = 0; i < 5; i++)
      vq.push_back(mkv(1, 2'b01, 3'b100, 3'b000, 2'b00, 0, 32'h0, 0, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0));
    vq.push_back(mkv(1, 2'b01, 3'b100, 3'b000, 2'b00, 1, 32'hDEADBEEF, 0, 1, 3'b100, 0, 2'b01, 2'b00, 32'hDEADBEEF));
    vq.push_back(mkv(1, 2'b00, 3'b000, 3'b000, 2'b00, 0, 32'h0, 0, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0));
    vq.push_back(mkv(1, 2'b00, 3'b000, 3'b000, 2'b00, 0, 32'h0, 0, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0));
    // Port 1 byte write; memory data on completion must not reach rdata.
    vq.push_back(mkv(1, 2'b10, 3'b000, 3'b001, 2'b10, 0, 32'h0, 1, 2, 3'b001, 1, 2'b00, 2'b00, 32'h0));
    vq.push_back(mkv(1, 2'b10, 3'b000, 3'b001, 2'b10, 0, 32'h0, 0, 2, 3'b001, 1, 2'b00, 2'b00, 32'h0));
    vq.push_back(mkv(1, 2'b10, 3'b000, 3'b001, 2'b10, 1, 32'hFFFFFFFF, 0, 2, 3'b001, 1, 2'b10, 2'b00, 32'h0));
    vq.push_back(mkv(1, 2'b00, 3'b000, 3'b000, 2'b00, 0, 32'h0, 0, 2, 3'b001, 1, 2'b00, 2'b00, 32'h0));
    // Port 1 illegal size: done+err next cycle, no strobe.
    vq.push_back(mkv(1, 2'b10, 3'b000, 3'b000, 2'b00, 0, 32'h0, 0, 2, 3'b000, 0, 2'b10, 2'b10, 32'h0));
    vq.push_back(mkv(1, 2'b00, 3'b000, 3'b000, 2'b00, 0, 32'h0, 0, 2, 3'b000, 0, 2'b00, 2'b00, 32'h0));
    // Reset, then tie: port 0 first, then port 1, alternating.
    vq.push_back(mkv(0, 2'b00, 3'b000, 3'b000, 2'b00, 0, 32'h0, 0, 0, 3'b000, 0, 2'b00, 2'b00, 32'h0));
    vq.push_back(mkv(1, 2'b11, 3'b100, 3'b010, 2'b00, 0, 32'h0, 1, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0));
    vq.push_back(mkv(1, 2'b11, 3'b100, 3'b010, 2'b00, 0, 32'h0, 0, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0));
    vq.push_back(mkv(1, 2'b11, 3'b100, 3'b010, 2'b00, 1, 32'h1, 0, 1, 3'b100, 0, 2'b01, 2'b00, 32'h1));
    vq.push_back(mkv(1, 2'b10, 3'b100, 3'b010, 2'b00, 0, 32'h0, 0, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0));
    vq.push_back(mkv(1, 2'b10, 3'b100, 3'b010, 2'b00, 0, 32'h0, 1, 2, 3'b010, 0, 2'b00, 2'b00, 32'h0));
    vq.push_back(mkv(1, 2'b10, 3'b100, 3'b010, 2'b00, 0, 32'h0, 0, 2, 3'b010, 0, 2'b00, 2'b00, 32'h0));
    vq.push_back(mkv(1, 2'b10, 3'b100, 3'b010, 2'b00, 1, 32'hBEEF, 0, 2, 3'b010, 0, 2'b10, 2'b00, 32'hBEEF));
    vq.push_back(mkv(1, 2'b00, 3'b100, 3'b010, 2'b00, 0, 32'h0, 0, 2, 3'b010, 0, 2'b00, 2'b00, 32'h0));
    vq.push_back(mkv(1, 2'b11, 3'b100, 3'b010, 2'b00, 0, 32'h0, 1, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0));
    vq.push_back(mkv(1, 2'b11, 3'b100, 3'b010, 2'b00, 0, 32'h0, 0, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0));
    vq.push_back(mkv(1, 2'b11, 3'b100, 3'b010, 2'b00, 1, 32'h2, 0, 1, 3'b100, 0, 2'b01, 2'b00, 32'h2));
    vq.push_back(mkv(1, 2'b10, 3'b100, 3'b010, 2'b00, 0, 32'h0, 0, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0));
    vq.push_back(mkv(1, 2'b11, 3'b100, 3'b010, 2'b00, 0, 32'h0, 1, 2, 3'b010, 0, 2'b00, 2'b00, 32'h0));
    vq.push_back(mkv(1, 2'b11, 3'b100, 3'b010, 2'b00, 0, 32'h0, 0, 2, 3'b010, 0, 2'b00, 2'b00, 32'h0));
    vq.push_back(mkv(1, 2'b11, 3'b100, 3'b010, 2'b00, 1, 32'h3, 0, 2, 3'b010, 0, 2'b10, 2'b00, 32'h3));
    vq.push_back(mkv(1, 2'b01, 3'b100, 3'b010, 2'b00, 0, 32'h0, 0, 2, 3'b010, 0, 2'b00, 2'b00, 32'h0));
    vq.push_back(mkv(1, 2'b01, 3'b100, 3'b010, 2'b00, 0, 32'h0, 1, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0));
    vq.push_back(mkv(1, 2'b01, 3'b100, 3'b010, 2'b00, 0, 32'h0, 0, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0));
    vq.push_back(mkv(1, 2'b01, 3'b100, 3'b010, 2'b00, 1, 32'h4, 0, 1, 3'b100, 0, 2'b01, 2'b00, 32'h4));
    vq.push_back(mkv(1, 2'b00, 3'b100, 3'b010, 2'b00, 0, 32'h0, 0, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0));
    // Stray memory strobe in IDLE is ignored.
    vq.push_back(mkv(1, 2'b00, 3'b100, 3'b010, 2'b00, 1, 32'hFFFF0000, 0, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0));
    vq.push_back(mkv(1, 2'b00, 3'b100, 3'b010, 2'b00, 0, 32'h0, 0, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0));

    drive(0, 2'b00, 3'b000, 3'b000, 2'b00, 0, 32'h0);
    chk_reset("reset_state");

    for (int i = 0; i < vq.size(); i++) begin
      vec_t v;
      v = vq[i];
      drive(v.rst_n, v.req, v.b0, v.b1, v.wr, v.mdv, v.mdata);
      cmp($sformatf("vec%0d", i), v.e_dv, v.e_sel, v.e_bhw, v.e_wr, v.e_dn, v.e_er, v.e_rd);
    end

    // Port 1 times out after TO silent WAIT cycles; pending port 0 waits for the drain.
    step("to_grant", 1, 2'b10, 3'b100, 3'b100, 2'b00, 0, 32'h0, 1, 2, 3'b100, 0, 2'b00, 2'b00, 32'h0);
    for (int i = 1; i <= TO; i++)
      step($sformatf("to_wait%0d", i), 1, 2'b11, 3'b100, 3'b100, 2'b00, 0, 32'h0, 0, 2, 3'b100, 0, 2'b00, 2'b00, 32'h0);
    step("to_done", 1, 2'b11, 3'b100, 3'b100, 2'b00, 0, 32'h0, 0, 2, 3'b100, 0, 2'b10, 2'b10, 32'h0);
    for (int i = 0; i < 4; i++)
      step($sformatf("to_drain%0d", i), 1, 2'b01, 3'b100, 3'b100, 2'b00, 0, 32'h0, 0, 2, 3'b100, 0, 2'b00, 2'b00, 32'h0);
    step("to_late_dv", 1, 2'b01, 3'b100, 3'b100, 2'b00, 1, 32'hBAD0BAD0, 0, 2, 3'b100, 0, 2'b00, 2'b00, 32'h0);
    step("to_p0_issue", 1, 2'b01, 3'b100, 3'b100, 2'b00, 0, 32'h0, 1, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0);
    step("to_p0_wait", 1, 2'b01, 3'b100, 3'b100, 2'b00, 0, 32'h0, 0, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0);
    step("to_p0_done", 1, 2'b01, 3'b100, 3'b100, 2'b00, 1, 32'hCAFEF00D, 0, 1, 3'b100, 0, 2'b01, 2'b00, 32'hCAFEF00D);
    step("to_idle", 1, 2'b00, 3'b100, 3'b100, 2'b00, 0, 32'h0, 0, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0);

    // Completion landing on the last WAIT cycle wins over the timeout: no drain.
    step("pr_grant", 1, 2'b10, 3'b100, 3'b100, 2'b00, 0, 32'h0, 1, 2, 3'b100, 0, 2'b00, 2'b00, 32'h0);
    for (int i = 1; i <= TO; i++)
      step($sformatf("pr_wait%0d", i), 1, 2'b10, 3'b100, 3'b100, 2'b00, 0, 32'h0, 0, 2, 3'b100, 0, 2'b00, 2'b00, 32'h0);
    step("pr_done", 1, 2'b10, 3'b100, 3'b100, 2'b00, 1, 32'h600D600D, 0, 2, 3'b100, 0, 2'b10, 2'b00, 32'h600D600D);
    step("pr_back_idle", 1, 2'b01, 3'b100, 3'b100, 2'b00, 0, 32'h0, 0, 2, 3'b100, 0, 2'b00, 2'b00, 32'h0);
    step("pr_p0_issue", 1, 2'b01, 3'b100, 3'b100, 2'b00, 0, 32'h0, 1, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0);
    step("pr_p0_wait", 1, 2'b01, 3'b100, 3'b100, 2'b00, 0, 32'h0, 0, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0);
    step("pr_p0_done", 1, 2'b01, 3'b100, 3'b100, 2'b00, 1, 32'h42, 0, 1, 3'b100, 0, 2'b01, 2'b00, 32'h42);
    step("pr_idle", 1, 2'b00, 3'b100, 3'b100, 2'b00, 0, 32'h0, 0, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0);

    // Reset while waiting on memory; its late strobe arrives after release.
    step("rs_issue", 1, 2'b01, 3'b100, 3'b000, 2'b00, 0, 32'h0, 1, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0);
    step("rs_wait0", 1, 2'b01, 3'b100, 3'b000, 2'b00, 0, 32'h0, 0, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0);
    step("rs_wait1", 1, 2'b01, 3'b100, 3'b000, 2'b00, 0, 32'h0, 0, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0);
    drive(0, 2'b00, 3'b000, 3'b000, 2'b00, 0, 32'h0);
    chk_reset("rs_reset_in_wait");
    step("rs_release", 1, 2'b00, 3'b000, 3'b000, 2'b00, 0, 32'h0, 0, 0, 3'b000, 0, 2'b00, 2'b00, 32'h0);
    step("rs_stray_dv", 1, 2'b00, 3'b000, 3'b000, 2'b00, 1, 32'hDEAD0000, 0, 0, 3'b000, 0, 2'b00, 2'b00, 32'h0);
    step("rs_quiet", 1, 2'b00, 3'b000, 3'b000, 2'b00, 0, 32'h0, 0, 0, 3'b000, 0, 2'b00, 2'b00, 32'h0);
    step("rs_p0_issue", 1, 2'b01, 3'b100, 3'b000, 2'b00, 0, 32'h0, 1, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0);
    step("rs_p0_wait", 1, 2'b01, 3'b100, 3'b000, 2'b00, 0, 32'h0, 0, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0);
    step("rs_p0_done", 1, 2'b01, 3'b100, 3'b000, 2'b00, 1, 32'h13579BDF, 0, 1, 3'b100, 0, 2'b01, 2'b00, 32'h13579BDF);
    step("rs_idle", 1, 2'b00, 3'b000, 3'b000, 2'b00, 0, 32'h0, 0, 1, 3'b100, 0, 2'b00, 2'b00, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
